// File: rtl/ensemble_vote_scheduler_if.sv
// AXI-Stream channel bundle shared by the host, classifier and vote streams.
interface ensemble_vote_scheduler_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (output tdata, tkeep, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/ensemble_vote_scheduler.sv
// Broadcasts each feature frame to three classifiers, collects one result per lane
// and emits a majority-vote beat; a watchdog bounds the wait on a stalled classifier.
module ensemble_vote_scheduler #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned KEEP_WIDTH     = DATA_WIDTH / 8,
   parameter int unsigned CLASS_WIDTH    = 8,
   parameter int unsigned TIE_LANE       = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst_n,
   ensemble_vote_scheduler_if.slave    s_axis,
   ensemble_vote_scheduler_if.master   f1_axis,
   ensemble_vote_scheduler_if.master   f2_axis,
   ensemble_vote_scheduler_if.master   f3_axis,
   ensemble_vote_scheduler_if.slave    r1_axis,
   ensemble_vote_scheduler_if.slave    r2_axis,
   ensemble_vote_scheduler_if.slave    r3_axis,
   ensemble_vote_scheduler_if.master   m_axis
);
   localparam int unsigned NLANE = 3;
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic WD_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [1:0] TIE_IDX = 2'(TIE_LANE - 1);

   typedef enum logic [1:0] {DISPATCH, COLLECT, EMIT} state_t;

   state_t                 state_q, state_d;
   logic [NLANE-1:0]       sent_q, sent_d, got_q, got_d, stale_q, stale_d;
   logic [NLANE-1:0]       r_ready_q, r_ready_d;
   logic [CLASS_WIDTH-1:0] label_q [NLANE];
   logic [CLASS_WIDTH-1:0] label_d [NLANE];
   logic                   proto_q, proto_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
   logic [NLANE-1:0]       f_valid_c, r_hs, cap;
   logic                   s_ready_c;

   logic [NLANE-1:0]       f_tready, r_tvalid, r_tlast;
   logic [CLASS_WIDTH-1:0] r_label [NLANE];
   logic                   unused_r;

   assign f_tready   = {f3_axis.tready, f2_axis.tready, f1_axis.tready};
   assign r_tvalid   = {r3_axis.tvalid, r2_axis.tvalid, r1_axis.tvalid};
   assign r_tlast    = {r3_axis.tlast, r2_axis.tlast, r1_axis.tlast};
   assign r_label[0] = r1_axis.tdata[CLASS_WIDTH-1:0];
   assign r_label[1] = r2_axis.tdata[CLASS_WIDTH-1:0];
   assign r_label[2] = r3_axis.tdata[CLASS_WIDTH-1:0];
   assign unused_r   = ^{r1_axis.tdata, r1_axis.tkeep, r2_axis.tdata, r2_axis.tkeep,
                         r3_axis.tdata, r3_axis.tkeep};

   // Majority over received lanes; tie-break lane, then lowest received lane.
   function automatic logic [DATA_WIDTH-1:0] vote_beat(input logic [NLANE-1:0] mask,
                                                       input logic [CLASS_WIDTH-1:0] lab [NLANE],
                                                       input logic tmo, input logic perr);
      logic [DATA_WIDTH-1:0]  beat;
      logic [CLASS_WIDTH-1:0] win;
      logic [1:0]             votes;
      logic                   tie, m12, m13, m23;
      m12   = mask[0] & mask[1] & (lab[0] == lab[1]);
      m13   = mask[0] & mask[2] & (lab[0] == lab[2]);
      m23   = mask[1] & mask[2] & (lab[1] == lab[2]);
      win   = lab[0];
      votes = 2'd2;
      tie   = 1'b0;
      if (m12) begin
         votes = m13 ? 2'd3 : 2'd2;
      end else if (m13) begin
         win = lab[0];
      end else if (m23) begin
         win = lab[1];
      end else if (mask == '0) begin
         win   = '0;
         votes = 2'd0;
      end else begin
         tie   = 1'b1;
         votes = 2'd1;
         if (mask[TIE_IDX])  win = lab[TIE_IDX];
         else if (mask[0])   win = lab[0];
         else if (mask[1])   win = lab[1];
         else                win = lab[2];
      end
      beat                    = '0;
      beat[CLASS_WIDTH-1:0]   = win;
      beat[9:8]               = votes;
      beat[12:10]             = mask;
      beat[13]                = tmo;
      beat[14]                = tie;
      beat[15]                = perr;
      return beat;
   endfunction

   // Next-state, capture and vote logic.
   always_comb begin
      state_d   = state_q;
      sent_d    = sent_q;
      got_d     = got_q;
      label_d   = label_q;
      proto_d   = proto_q;
      cnt_d     = cnt_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      f_valid_c = '0;
      s_ready_c = 1'b0;

      r_hs    = r_ready_q & r_tvalid;
      cap     = r_hs & ~stale_q;
      stale_d = stale_q & ~r_hs;
      for (int i = 0; i < 3; i++) begin
         if (cap[i]) begin
            got_d[i]   = 1'b1;
            label_d[i] = r_label[i];
            if (!r_tlast[i]) proto_d = 1'b1;
         end
      end

      unique case (state_q)
         DISPATCH: begin
            f_valid_c = {NLANE{s_axis.tvalid}} & ~sent_q;
            s_ready_c = &(sent_q | f_tready);
            sent_d    = sent_q | (f_valid_c & f_tready);
            if (s_axis.tvalid && s_ready_c) begin
               sent_d = '0;
               if (s_axis.tlast) begin
                  state_d = COLLECT;
                  cnt_d   = '0;
               end
            end
         end
         COLLECT: begin
            if (&got_d) begin
               state_d   = EMIT;
               m_valid_d = 1'b1;
               m_data_d  = vote_beat(got_d, label_d, 1'b0, proto_d);
            end else if (WD_EN && (cnt_q == CNT_LAST)) begin
               state_d   = EMIT;
               stale_d   = stale_d | ~got_d;
               m_valid_d = 1'b1;
               m_data_d  = vote_beat(got_d, label_d, 1'b1, proto_d);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         EMIT: begin
            if (m_axis.tready) begin
               state_d   = DISPATCH;
               got_d     = '0;
               proto_d   = 1'b0;
               m_valid_d = 1'b0;
            end
         end
         default: state_d = DISPATCH;
      endcase

      // Stale lanes always drain; fresh lanes only until captured, never in EMIT.
      r_ready_d = stale_d | (~got_d & {NLANE{state_d != EMIT}});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= DISPATCH;
         sent_q    <= '0;
         got_q     <= '0;
         stale_q   <= '0;
         label_q   <= '{default: '0};
         proto_q   <= 1'b0;
         cnt_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         r_ready_q <= '0;
      end else begin
         state_q   <= state_d;
         sent_q    <= sent_d;
         got_q     <= got_d;
         stale_q   <= stale_d;
         label_q   <= label_d;
         proto_q   <= proto_d;
         cnt_q     <= cnt_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         r_ready_q <= r_ready_d;
      end
   end

   assign s_axis.tready  = s_ready_c;
   assign f1_axis.tvalid = f_valid_c[0];
   assign f2_axis.tvalid = f_valid_c[1];
   assign f3_axis.tvalid = f_valid_c[2];
   assign f1_axis.tdata  = s_axis.tdata;
   assign f2_axis.tdata  = s_axis.tdata;
   assign f3_axis.tdata  = s_axis.tdata;
   assign f1_axis.tkeep  = s_axis.tkeep;
   assign f2_axis.tkeep  = s_axis.tkeep;
   assign f3_axis.tkeep  = s_axis.tkeep;
   assign f1_axis.tlast  = s_axis.tlast;
   assign f2_axis.tlast  = s_axis.tlast;
   assign f3_axis.tlast  = s_axis.tlast;
   assign r1_axis.tready = r_ready_q[0];
   assign r2_axis.tready = r_ready_q[1];
   assign r3_axis.tready = r_ready_q[2];
   assign m_axis.tvalid  = m_valid_q;
   assign m_axis.tdata   = m_data_q;
   assign m_axis.tkeep   = '1;
   assign m_axis.tlast   = 1'b1;
endmodule

// File: tb/tb_ensemble_vote_scheduler.sv
// Directed plus randomized frames checked against a label-counting vote model.
module tb_ensemble_vote_scheduler;
   localparam int unsigned DW = 32;
   localparam int unsigned KW = 4;
   localparam int unsigned TIE = 3;
   localparam int unsigned TMO = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ensemble_vote_scheduler_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW))
      s_axis (), f1_axis (), f2_axis (), f3_axis (), r1_axis (), r2_axis (), r3_axis (), m_axis ();

   ensemble_vote_scheduler #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_WIDTH(8), .TIE_LANE(TIE), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_axis(s_axis),
      .f1_axis(f1_axis), .f2_axis(f2_axis), .f3_axis(f3_axis),
      .r1_axis(r1_axis), .r2_axis(r2_axis), .r3_axis(r3_axis), .m_axis(m_axis)
   );

   logic [36:0] f1_log[$], f2_log[$], f3_log[$], exp_f[$];

   always @(negedge clk) begin
      if (f1_axis.tvalid && f1_axis.tready) f1_log.push_back({f1_axis.tlast, f1_axis.tkeep, f1_axis.tdata});
      if (f2_axis.tvalid && f2_axis.tready) f2_log.push_back({f2_axis.tlast, f2_axis.tkeep, f2_axis.tdata});
      if (f3_axis.tvalid && f3_axis.tready) f3_log.push_back({f3_axis.tlast, f3_axis.tkeep, f3_axis.tdata});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Count how many received lanes hold each label; the best count decides.
   function automatic logic [31:0] ref_vote(input bit [2:0] mask, input int unsigned lab [3],
                                            input bit tmo, input bit perr);
      int unsigned best_lab = 0, best_cnt = 0, votes = 0, cnt;
      bit tie = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (mask[i]) begin
            cnt = 0;
            for (int j = 0; j < 3; j++) if (mask[j] && lab[j] == lab[i]) cnt++;
            if (cnt > best_cnt) begin best_cnt = cnt; best_lab = lab[i]; end
         end
      end
      if (mask == 3'b000) begin
         best_lab = 0; votes = 0;
      end else if (best_cnt >= 2) begin
         votes = best_cnt;
      end else begin
         tie = 1'b1; votes = 1;
         if (mask[TIE-1]) best_lab = lab[TIE-1];
         else for (int i = 2; i >= 0; i--) if (mask[i]) best_lab = lab[i];
      end
      return {16'h0, perr, tie, tmo, mask, votes[1:0], best_lab[7:0]};
   endfunction

   task automatic set_f_ready(input bit [2:0] v);
      f1_axis.tready = v[0]; f2_axis.tready = v[1]; f3_axis.tready = v[2];
   endtask

   task automatic send_frame(input int nb, input int sl, input int sb, input int slen, output int s_low);
      logic [36:0] beats[$];
      int idx = 0, left = slen, cyc = 0;
      s_low = 0;
      for (int i = 0; i < nb; i++) begin
         logic [36:0] b;
         b[31:0]  = $urandom();
         b[35:32] = 4'($urandom());
         b[36]    = (i == nb - 1);
         beats.push_back(b);
         exp_f.push_back(b);
      end
      while (idx < nb && cyc < 200) begin
         @(posedge clk); #1;
         s_axis.tvalid = 1'b1;
         {s_axis.tlast, s_axis.tkeep, s_axis.tdata} = beats[idx];
         set_f_ready({!(sl == 3 && idx == sb && left > 0), !(sl == 2 && idx == sb && left > 0),
                      !(sl == 1 && idx == sb && left > 0)});
         @(negedge clk);
         if (sl != 0 && idx == sb && left > 0) left--;
         if (s_axis.tready) idx++; else s_low++;
         cyc++;
      end
      @(posedge clk); #1;
      s_axis.tvalid = 1'b0;
      set_f_ready(3'b111);
      check("frame_consumed", 64'(idx), 64'(nb));
   endtask

   task automatic check_feat(input string tag);
      check({tag, "_f1_beats"}, 64'(f1_log.size()), 64'(exp_f.size()));
      check({tag, "_f2_beats"}, 64'(f2_log.size()), 64'(exp_f.size()));
      check({tag, "_f3_beats"}, 64'(f3_log.size()), 64'(exp_f.size()));
      for (int i = 0; i < exp_f.size(); i++) begin
         if (i < f1_log.size()) check({tag, "_f1_beat"}, 64'(f1_log[i]), 64'(exp_f[i]));
         if (i < f2_log.size()) check({tag, "_f2_beat"}, 64'(f2_log[i]), 64'(exp_f[i]));
         if (i < f3_log.size()) check({tag, "_f3_beat"}, 64'(f3_log[i]), 64'(exp_f[i]));
      end
      f1_log.delete(); f2_log.delete(); f3_log.delete(); exp_f.delete();
   endtask

   task automatic give_results(input bit [2:0] lanes, input int unsigned lab [3], input bit [2:0] tl);
      bit [2:0] pend = lanes;
      int n = 0;
      r1_axis.tdata = $urandom(); r1_axis.tdata[7:0] = lab[0][7:0]; r1_axis.tlast = tl[0];
      r2_axis.tdata = $urandom(); r2_axis.tdata[7:0] = lab[1][7:0]; r2_axis.tlast = tl[1];
      r3_axis.tdata = $urandom(); r3_axis.tdata[7:0] = lab[2][7:0]; r3_axis.tlast = tl[2];
      while (pend != 3'b000 && n < 60) begin
         @(posedge clk); #1;
         r1_axis.tvalid = pend[0]; r2_axis.tvalid = pend[1]; r3_axis.tvalid = pend[2];
         @(negedge clk);
         if (r1_axis.tvalid && r1_axis.tready) pend[0] = 1'b0;
         if (r2_axis.tvalid && r2_axis.tready) pend[1] = 1'b0;
         if (r3_axis.tvalid && r3_axis.tready) pend[2] = 1'b0;
         n++;
      end
      @(posedge clk); #1;
      r1_axis.tvalid = 1'b0; r2_axis.tvalid = 1'b0; r3_axis.tvalid = 1'b0;
      check("result_handshake", 64'(pend), 64'(0));
   endtask

   task automatic wait_emit(output logic [31:0] d, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!m_axis.tvalid && cyc < 100);
      d = m_axis.tdata;
   endtask

   task automatic accept_emit(input int hold, input logic [31:0] d);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); @(negedge clk);
         check("hold_data", 64'(m_axis.tdata), 64'(d));
         check("hold_s_ready", 64'(s_axis.tready), 64'(0));
      end
      @(posedge clk); #1;
      m_axis.tready = 1'b1;
      @(posedge clk); #1;
      m_axis.tready = 1'b0;
      @(negedge clk);
      check("emit_drop", 64'(m_axis.tvalid), 64'(0));
   endtask

   task automatic run_frame(input string tag, input int nb, input int sl, input int sb, input int slen,
                            input bit pre, input int unsigned lab [3], input bit [2:0] tl, input int hold);
      logic [31:0] d;
      int cyc, slow;
      if (pre) give_results(3'b111, lab, tl);
      send_frame(nb, sl, sb, slen, slow);
      check({tag, "_s_low"}, 64'(slow), 64'((sl != 0 && sb < nb) ? slen : 0));
      check_feat(tag);
      if (!pre) give_results(3'b111, lab, tl);
      wait_emit(d, cyc);
      check({tag, "_latency"}, 64'(cyc), 64'(pre ? 2 : 1));
      check({tag, "_vote"}, 64'(d), 64'(ref_vote(3'b111, lab, 1'b0, !(&tl))));
      accept_emit(hold, d);
   endtask

   initial begin
      int unsigned lab [3];
      int unsigned late [3];
      logic [31:0] d;
      int cyc, slow;

      s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 1'b0;
      set_f_ready(3'b000);
      r1_axis.tvalid = 1'b0; r2_axis.tvalid = 1'b0; r3_axis.tvalid = 1'b0;
      r1_axis.tkeep = '1; r2_axis.tkeep = '1; r3_axis.tkeep = '1;
      m_axis.tready = 1'b0;

      #2;
      check("rst_m_tvalid", 64'(m_axis.tvalid), 64'(0));
      check("rst_m_tdata", 64'(m_axis.tdata), 64'(0));
      check("rst_r_tready", 64'({r3_axis.tready, r2_axis.tready, r1_axis.tready}), 64'(0));
      check("rst_f_tvalid", 64'({f3_axis.tvalid, f2_axis.tvalid, f1_axis.tvalid}), 64'(0));
      check("rst_s_tready", 64'(s_axis.tready), 64'(0));
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      set_f_ready(3'b111);

      // 4-beat frame, results 5/5/7
      lab = '{5, 5, 7};
      send_frame(4, 0, 0, 0, slow);
      check("t1_s_low", 64'(slow), 64'(0));
      check_feat("t1");
      give_results(3'b111, lab, 3'b111);
      wait_emit(d, cyc);
      check("t1_latency", 64'(cyc), 64'(1));
      check("t1_vote", 64'(d), 64'(ref_vote(3'b111, lab, 1'b0, 1'b0)));
      check("t1_tkeep", 64'(m_axis.tkeep), 64'(4'hf));
      check("t1_tlast", 64'(m_axis.tlast), 64'(1));
      accept_emit(0, d);

      // lane 2 stalls beat 2 for three cycles
      lab = '{3, 9, 3};
      run_frame("stall", 4, 2, 1, 3, 1'b0, lab, 3'b111, 1);

      // no majority -> tie lane wins; downstream holds off for five cycles
      lab = '{1, 2, 3};
      run_frame("tie", 2, 0, 0, 0, 1'b1, lab, 3'b111, 5);

      // lane 3 withheld -> watchdog
      lab = '{1, 2, 0};
      give_results(3'b011, lab, 3'b111);
      send_frame(3, 0, 0, 0, slow);
      check_feat("tmo");
      wait_emit(d, cyc);
      check("tmo_latency", 64'(cyc), 64'(TMO + 1));
      check("tmo_vote", 64'(d), 64'(ref_vote(3'b011, lab, 1'b1, 1'b0)));
      accept_emit(1, d);

      // late lane-3 result is discarded; next frame's lane-3 result counts
      late = '{0, 0, 9};
      give_results(3'b100, late, 3'b111);
      lab = '{4, 6, 6};
      run_frame("late", 2, 0, 0, 0, 1'b0, lab, 3'b111, 0);

      // protocol error is sticky to its own vote beat only
      lab = '{2, 2, 2};
      run_frame("proto", 1, 0, 0, 0, 1'b0, lab, 3'b101, 0);

      for (int k = 0; k < 12; k++) begin
         int unsigned rl [3];
         bit [2:0] tl;
         rl[0] = $urandom_range(0, 3); rl[1] = $urandom_range(0, 3); rl[2] = $urandom_range(0, 3);
         tl = ($urandom_range(0, 5) == 0) ? 3'($urandom()) : 3'b111;
         run_frame("rand", int'($urandom_range(1, 5)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), rl, tl, int'($urandom_range(0, 2)));
      end

      // reset in the middle of a frame with one result already captured
      lab = '{2, 2, 1};
      give_results(3'b001, lab, 3'b111);
      @(posedge clk); #1;
      s_axis.tvalid = 1'b1; s_axis.tdata = $urandom(); s_axis.tkeep = 4'hf; s_axis.tlast = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      s_axis.tvalid = 1'b0;
      set_f_ready(3'b000);
      #2;
      check("mid_rst_m_tvalid", 64'(m_axis.tvalid), 64'(0));
      check("mid_rst_m_tdata", 64'(m_axis.tdata), 64'(0));
      check("mid_rst_r_tready", 64'({r3_axis.tready, r2_axis.tready, r1_axis.tready}), 64'(0));
      check("mid_rst_f_tvalid", 64'({f3_axis.tvalid, f2_axis.tvalid, f1_axis.tvalid}), 64'(0));
      check("mid_rst_s_tready", 64'(s_axis.tready), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      set_f_ready(3'b111);
      f1_log.delete(); f2_log.delete(); f3_log.delete(); exp_f.delete();
      lab = '{7, 8, 8};
      run_frame("post_rst", 3, 0, 0, 0, 1'b0, lab, 3'b111, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
